// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the PC redirect controller.
// FSM state encodings and default PC geometry.
package pc_redirect_ctrl_pkg;

  localparam int          DEF_PC_W     = 16;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

endpackage

// File: rtl/redirect_flush_cnt.sv
// Loadable down-counter timing the IF/ID flush window.
// Counts to zero and stops; nonzero marks an open window.
module redirect_flush_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         nonzero
);

  logic [W-1:0] cnt;

  // Load on a committed redirect, otherwise drain one per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign nonzero = (cnt != '0);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC register, fetch handshake and redirect/flush control.
// Optional REDIRECT_STATS_EN adds a saturating redirect counter.
import pc_redirect_ctrl_pkg::*;

module pc_redirect_ctrl #(
  parameter int              PC_W         = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC     = PC_W'(DEF_RESET_PC),
  parameter int              FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            stall,
  input  logic            halt,
  input  logic            imem_ready,
  output logic [PC_W-1:0] fetch_pc,
  output logic            fetch_valid,
  output logic [PC_W-1:0] pc_plus2,
  output logic            flush_ifid,
  output logic            halted
`ifdef REDIRECT_STATS_EN
  ,
  output logic [15:0]     redirect_cnt
`endif
);

  state_t          state;
  logic [PC_W-1:0] pending;
  logic [PC_W-1:0] target;
  logic            flush_nz;
  logic            eff_redir;
  logic            mem_ok;
  logic            commit;

  assign pc_plus2   = fetch_pc + PC_W'(2);
  assign target     = {redirect_pc[PC_W-1:1], 1'b0};
  assign flush_ifid = flush_nz | (state == ST_WAIT_MEM);
  assign eff_redir  = redirect_en & ~stall & ~flush_ifid;
  // No request is outstanding in the start cycle after reset.
  assign mem_ok     = imem_ready & fetch_valid;
  assign commit     = ((state == ST_RUN) & eff_redir & mem_ok)
                    | ((state == ST_WAIT_MEM) & imem_ready);

  redirect_flush_cnt #(
    .W(2)
  ) u_flush (
    .clk     (clk),
    .rst     (rst),
    .load    (commit),
    .load_val(2'(FLUSH_CYCLES)),
    .nonzero (flush_nz)
  );

  // Fetch FSM: sequential advance, redirect, deferred redirect, halt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      fetch_pc    <= RESET_PC;
      pending     <= '0;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (eff_redir && mem_ok) begin
            fetch_pc    <= target;
            fetch_valid <= 1'b1;
          end else if (eff_redir) begin
            pending     <= target;
            state       <= ST_WAIT_MEM;
            fetch_valid <= 1'b1;
          end else if (halt && !stall) begin
            state       <= ST_HALT;
            fetch_valid <= 1'b0;
            halted      <= 1'b1;
          end else begin
            fetch_valid <= 1'b1;
            if (!stall && mem_ok) begin
              fetch_pc <= pc_plus2;
            end
          end
        end
        ST_WAIT_MEM: begin
          if (imem_ready) begin
            fetch_pc <= pending;
            state    <= ST_RUN;
          end
        end
        ST_HALT: begin
          fetch_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

`ifdef REDIRECT_STATS_EN
  // Count committed redirects, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_cnt <= '0;
    end else if (commit && (redirect_cnt != 16'hFFFF)) begin
      redirect_cnt <= redirect_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl.
// Directed scenarios plus randomized traffic against a reference model.
module tb_pc_redirect_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        halt;
  logic        imem_ready;
  logic [15:0] fetch_pc;
  logic        fetch_valid;
  logic [15:0] pc_plus2;
  logic        flush_ifid;
  logic        halted;
  logic [15:0] redirect_cnt;

  int errors = 0;
  int checks = 0;

  pc_redirect_ctrl #(
    .PC_W        (16),
    .RESET_PC    (16'h0000),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .halt       (halt),
    .imem_ready (imem_ready),
    .fetch_pc   (fetch_pc),
    .fetch_valid(fetch_valid),
    .pc_plus2   (pc_plus2),
    .flush_ifid (flush_ifid),
    .halted     (halted)
`ifdef REDIRECT_STATS_EN
    ,
    .redirect_cnt(redirect_cnt)
`endif
  );

`ifndef REDIRECT_STATS_EN
  assign redirect_cnt = 16'h0000;
`endif

  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1; redirect_en = 0; redirect_pc = 0;
    stall = 0; halt = 0; imem_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({fetch_pc, fetch_valid, flush_ifid, halted, pc_plus2}
        !== {16'h0000, 1'b0, 1'b0, 1'b0, 16'h0002}) begin
      errors++;
      $display("FAIL reset: got pc=%h v=%b f=%b h=%b p2=%h want 0000 0 0 0 0002",
               fetch_pc, fetch_valid, flush_ifid, halted, pc_plus2);
    end
  endtask

  task automatic test_sequential;
    logic [15:0] ep;
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      ep = 16'(2 * i);
      checks++;
      if ({fetch_pc, fetch_valid, flush_ifid} !== {ep, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL seq[%0d]: got pc=%h v=%b f=%b want pc=%h v=1 f=0",
                 i, fetch_pc, fetch_valid, flush_ifid, ep);
      end
    end
  endtask

  task automatic test_redirect;
    logic [15:0] ep [3] = '{16'h0040, 16'h0042, 16'h0044};
    logic        ef [3] = '{1'b1, 1'b1, 1'b0};
    redirect_en = 1; redirect_pc = 16'h0041;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({fetch_pc, flush_ifid, pc_plus2} !== {ep[i], ef[i], ep[i] + 16'd2}) begin
        errors++;
        $display("FAIL redirect[%0d]: got pc=%h f=%b p2=%h want pc=%h f=%b",
                 i, fetch_pc, flush_ifid, pc_plus2, ep[i], ef[i]);
      end
    end
    redirect_en = 0;
  endtask

  task automatic test_wait_mem;
    logic [15:0] ep [6] = '{16'h0044, 16'h0044, 16'h0044,
                            16'h0080, 16'h0082, 16'h0084};
    logic        ef [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    imem_ready = 0; redirect_en = 1; redirect_pc = 16'h0080;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({fetch_pc, flush_ifid, fetch_valid} !== {ep[i], ef[i], 1'b1}) begin
        errors++;
        $display("FAIL wait_mem[%0d]: got pc=%h f=%b v=%b want pc=%h f=%b v=1",
                 i, fetch_pc, flush_ifid, fetch_valid, ep[i], ef[i]);
      end
      if (i == 0) redirect_pc = 16'h0090;
      if (i == 2) begin imem_ready = 1; redirect_en = 0; end
    end
  endtask

  task automatic test_stall;
    logic [15:0] ep [5] = '{16'h0084, 16'h0084, 16'h0100, 16'h0102, 16'h0104};
    logic        ef [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    stall = 1; redirect_en = 1; redirect_pc = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({fetch_pc, flush_ifid} !== {ep[i], ef[i]}) begin
        errors++;
        $display("FAIL stall[%0d]: got pc=%h f=%b want pc=%h f=%b",
                 i, fetch_pc, flush_ifid, ep[i], ef[i]);
      end
      if (i == 1) stall = 0;
      if (i == 2) redirect_en = 0;
    end
  endtask

  task automatic test_wrap_halt;
    logic [15:0] ep [7] = '{16'hFFFE, 16'h0000, 16'h0002, 16'h0002,
                            16'h0002, 16'h0002, 16'h0002};
    logic        ev [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        eh [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    redirect_en = 1; redirect_pc = 16'hFFFF;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({fetch_pc, fetch_valid, halted, pc_plus2}
          !== {ep[i], ev[i], eh[i], ep[i] + 16'd2}) begin
        errors++;
        $display("FAIL wrap_halt[%0d]: got pc=%h v=%b h=%b p2=%h want pc=%h v=%b h=%b",
                 i, fetch_pc, fetch_valid, halted, pc_plus2, ep[i], ev[i], eh[i]);
      end
      if (i == 0) redirect_en = 0;
      if (i == 2) halt = 1;
      if (i == 3) begin halt = 0; redirect_en = 1; redirect_pc = 16'h0300; end
    end
    redirect_en = 0;
`ifdef REDIRECT_STATS_EN
    checks++;
    if (redirect_cnt !== 16'd4) begin
      errors++;
      $display("FAIL stats_cnt: got %0d want 4", redirect_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_wait;
    rst = 1; #1;
    @(posedge clk); #1;
    rst = 0; imem_ready = 0;
    @(posedge clk); #1;
    redirect_en = 1; redirect_pc = 16'h0080;
    @(posedge clk); #1;
    checks++;
    if ({fetch_pc, flush_ifid} !== {16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL mid_wait_enter: got pc=%h f=%b want 0000 1", fetch_pc, flush_ifid);
    end
    #2 rst = 1; #1;
    checks++;
    if ({fetch_pc, fetch_valid, flush_ifid, halted, redirect_cnt}
        !== {16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL mid_wait_rst: got pc=%h v=%b f=%b h=%b cnt=%h want 0000 0 0 0 0000",
               fetch_pc, fetch_valid, flush_ifid, halted, redirect_cnt);
    end
    @(posedge clk); #1;
    rst = 0; redirect_en = 0; imem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({fetch_pc, fetch_valid, flush_ifid} !== {16'(2 * i), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL mid_wait_after[%0d]: got pc=%h v=%b f=%b want pc=%h v=1 f=0",
                 i, fetch_pc, fetch_valid, flush_ifid, 16'(2 * i));
      end
    end
  endtask

  // Reference model: fetch address, whether a redirect is parked waiting
  // for memory, how many flush cycles remain, and whether fetch has ended.
  task automatic test_random;
    int m_pc, m_pend, m_left, m_cnt, halt_age;
    bit m_valid, m_wait, m_halt, shadow, take;
    m_pc = 0; m_pend = 0; m_left = 0; m_cnt = 0; halt_age = 0;
    m_valid = 1; m_wait = 0; m_halt = 0;
    m_cnt = int'(redirect_cnt);
    m_pc = 4;
    for (int n = 0; n < 1500; n++) begin
      if (m_halt && halt_age > 3) begin
        rst = 1; #1;
        checks++;
        if ({fetch_pc, fetch_valid, flush_ifid, halted} !== {16'h0000, 3'b000}) begin
          errors++;
          $display("FAIL rand_rst[%0d]: got pc=%h v=%b f=%b h=%b want 0000 0 0 0",
                   n, fetch_pc, fetch_valid, flush_ifid, halted);
        end
        @(posedge clk); #1;
        rst = 0; redirect_en = 0; halt = 0;
        @(posedge clk); #1;
        m_pc = 0; m_pend = 0; m_left = 0; m_cnt = 0; halt_age = 0;
        m_valid = 1; m_wait = 0; m_halt = 0;
      end
      redirect_en = ($urandom_range(0, 3) == 0);
      redirect_pc = 16'($urandom);
      stall       = ($urandom_range(0, 4) == 0);
      halt        = ($urandom_range(0, 299) == 0);
      imem_ready  = ($urandom_range(0, 9) < 7);
      shadow = m_wait || (m_left > 0);
      m_left = (m_left > 0) ? m_left - 1 : 0;
      if (m_halt) begin
        halt_age++;
      end else if (m_wait) begin
        if (imem_ready) begin
          m_pc = m_pend; m_wait = 0; m_left = FC;
          m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        end
      end else begin
        take = redirect_en && !stall && !shadow;
        if (take && imem_ready) begin
          m_pc = int'(redirect_pc) / 2 * 2; m_left = FC;
          m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        end else if (take) begin
          m_pend = int'(redirect_pc) / 2 * 2; m_wait = 1;
        end else if (halt && !stall) begin
          m_halt = 1; m_valid = 0;
        end else if (!stall && imem_ready) begin
          m_pc = (m_pc + 2) % 65536;
        end
      end
      @(posedge clk); #1;
      checks++;
      if ({fetch_pc, fetch_valid, flush_ifid, halted, pc_plus2}
          !== {16'(m_pc), m_valid, (m_wait || m_left > 0), m_halt,
               16'((m_pc + 2) % 65536)}) begin
        errors++;
        $display("FAIL rand[%0d]: got pc=%h v=%b f=%b h=%b p2=%h want pc=%h v=%b f=%b h=%b",
                 n, fetch_pc, fetch_valid, flush_ifid, halted, pc_plus2,
                 16'(m_pc), m_valid, (m_wait || m_left > 0), m_halt);
      end
`ifdef REDIRECT_STATS_EN
      checks++;
      if (redirect_cnt !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL rand_cnt[%0d]: got %0d want %0d", n, redirect_cnt, m_cnt);
      end
`endif
    end
    redirect_en = 0; stall = 0; halt = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_wait_mem();
    test_stall();
    test_wrap_halt();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
